// File: rtl/dmem_qos_arbiter_pkg.sv
// Shared types and defaults for the weighted round-robin data-memory arbiter.
package dmem_qos_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RELOAD = 2'd1,
        S_BUSY   = 2'd2
    } dmem_qos_state_e;

    localparam int DMEM_QOS_N_REQ_DEF   = 4;
    localparam int DMEM_QOS_TIMEOUT_DEF = 256;

endpackage

// File: rtl/dmem_qos_arbiter_if.sv
// Single data-memory port: request fields travel master->slave, response fields slave->master.
interface harvos_dmem_if;

    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rvalid;
    logic        fault;

    modport master (
        output req, we, be, addr, wdata,
        input  rdata, rvalid, fault
    );

    modport slave (
        input  req, we, be, addr, wdata,
        output rdata, rvalid, fault
    );

endinterface

// File: rtl/dmem_qos_arbiter_rr_pick.sv
// Rotating-priority encoder: first set bit of mask at or after start, wrapping mod N.
module harvos_rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  mask,
    input  logic [IW-1:0] start,
    output logic          found,
    output logic [IW-1:0] idx
);

    logic [N-1:0]  rot;
    logic [IW-1:0] off;
    logic [IW:0]   sum;

    // Rotating the mask down by start turns the search into a plain lowest-bit find.
    assign rot = N'({mask, mask} >> start);

    always_comb begin
        found = 1'b0;
        off   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found = 1'b1;
                off   = IW'(k);
            end
        end
    end

    assign sum = {1'b0, start} + {1'b0, off};
    assign idx = (sum >= (IW + 1)'(N)) ? IW'(sum - (IW + 1)'(N)) : sum[IW-1:0];

endmodule

// File: rtl/dmem_qos_arbiter.sv
// Weighted round-robin owner of the shared data-memory port, with per-requester credits
// and a response timeout that completes a hung transaction with a fault.
module dmem_qos_arbiter
    import dmem_qos_arbiter_pkg::*;
#(
    parameter int N_REQ       = DMEM_QOS_N_REQ_DEF,
    parameter int WEIGHT_W    = 4,
    parameter int TIMEOUT_CYC = DMEM_QOS_TIMEOUT_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ-1:0]          req_we,
    input  logic [4*N_REQ-1:0]        req_be,
    input  logic [32*N_REQ-1:0]       req_addr,
    input  logic [32*N_REQ-1:0]       req_wdata,
    input  logic [WEIGHT_W*N_REQ-1:0] cfg_weight,
    output logic [N_REQ-1:0]          rsp_valid,
    output logic                      rsp_fault,
    output logic [31:0]               rsp_rdata,
    output logic [$clog2(N_REQ)-1:0]  grant_id,
    output logic                      busy,
    harvos_dmem_if.master             dmem
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    dmem_qos_state_e     state;
    dmem_qos_state_e     state_nxt;
    logic [WEIGHT_W-1:0] credit [N_REQ];
    logic [IW-1:0]       rr_ptr;
    logic [CW-1:0]       tcnt;
    logic [IW-1:0]       lat_id;
    logic                lat_we;
    logic [3:0]          lat_be;
    logic [31:0]         lat_addr;
    logic [31:0]         lat_wdata;

    logic [N_REQ-1:0]    eligible;
    logic                pick_found;
    logic [IW-1:0]       pick_idx;
    logic                xact_done;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            eligible[i] = req_valid[i] && (credit[i] != '0);
        end
    end

    harvos_rr_pick #(
        .N  (N_REQ),
        .IW (IW)
    ) u_pick (
        .mask  (eligible),
        .start (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // A real response always beats the timeout when both land in the same cycle.
    always_comb begin
        state_nxt = state;
        rsp_valid = '0;
        rsp_fault = 1'b0;
        rsp_rdata = '0;
        xact_done = 1'b0;
        case (state)
            S_IDLE: begin
                if (pick_found) begin
                    state_nxt = S_BUSY;
                end else if (|req_valid) begin
                    state_nxt = S_RELOAD;
                end
            end
            S_RELOAD: state_nxt = S_IDLE;
            S_BUSY: begin
                if (dmem.rvalid) begin
                    xact_done = 1'b1;
                    rsp_valid = N_REQ'(1) << lat_id;
                    rsp_fault = dmem.fault;
                    rsp_rdata = dmem.rdata;
                end else if (tcnt == CW'(TIMEOUT_CYC - 1)) begin
                    xact_done = 1'b1;
                    rsp_valid = N_REQ'(1) << lat_id;
                    rsp_fault = 1'b1;
                end
                if (xact_done) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            rr_ptr    <= '0;
            tcnt      <= '0;
            lat_id    <= '0;
            lat_we    <= 1'b0;
            lat_be    <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            for (int i = 0; i < N_REQ; i++) begin
                credit[i] <= '0;
            end
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (pick_found) begin
                        lat_id    <= pick_idx;
                        lat_we    <= req_we[pick_idx];
                        lat_be    <= req_be[4*pick_idx +: 4];
                        lat_addr  <= req_addr[32*pick_idx +: 32];
                        lat_wdata <= req_wdata[32*pick_idx +: 32];
                        rr_ptr    <= (pick_idx == IW'(N_REQ - 1)) ? '0 : pick_idx + IW'(1);
                        tcnt      <= '0;
                    end
                end
                S_RELOAD: begin
                    for (int i = 0; i < N_REQ; i++) begin
                        credit[i] <= (cfg_weight[WEIGHT_W*i +: WEIGHT_W] == '0) ?
                                     WEIGHT_W'(1) : cfg_weight[WEIGHT_W*i +: WEIGHT_W];
                    end
                end
                S_BUSY: begin
                    if (xact_done) begin
                        if (credit[lat_id] != '0) begin
                            credit[lat_id] <= credit[lat_id] - WEIGHT_W'(1);
                        end
                    end else begin
                        tcnt <= tcnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Memory-side fields come only from the latch so requesters can move on mid-transaction.
    assign busy       = (state == S_BUSY);
    assign dmem.req   = busy;
    assign dmem.we    = lat_we;
    assign dmem.be    = lat_be;
    assign dmem.addr  = lat_addr;
    assign dmem.wdata = lat_wdata;
    assign grant_id   = lat_id;

endmodule

// File: tb/tb_dmem_qos_arbiter.sv
// Randomized self-checking bench for dmem_qos_arbiter against a credit/round-robin reference model.
module tb_dmem_qos_arbiter;

    localparam int N  = 4;
    localparam int WW = 4;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_we;
    logic [4*N-1:0]  req_be;
    logic [32*N-1:0] req_addr;
    logic [32*N-1:0] req_wdata;
    logic [WW*N-1:0] cfg_weight;
    logic [N-1:0]  rsp_valid;
    logic          rsp_fault;
    logic [31:0]   rsp_rdata;
    logic [1:0]    grant_id;
    logic          busy;

    harvos_dmem_if dmem_if ();

    dmem_qos_arbiter #(
        .N_REQ       (N),
        .WEIGHT_W    (WW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_be     (req_be),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .cfg_weight (cfg_weight),
        .rsp_valid  (rsp_valid),
        .rsp_fault  (rsp_fault),
        .rsp_rdata  (rsp_rdata),
        .grant_id   (grant_id),
        .busy       (busy),
        .dmem       (dmem_if.master)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: remaining credits per requester and the next-search pointer.
    int m_credit [N];
    int m_rr;

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_credit[i] = 0;
        m_rr = 0;
    endtask

    // One arbitration decision: refill when nobody active has credit, then take the
    // first active requester with credit starting from the pointer.
    task automatic model_pick(input logic [N-1:0] act, output int g, output bit rl);
        bit any;
        int w;
        any = 1'b0;
        g   = -1;
        for (int i = 0; i < N; i++) if (act[i] && m_credit[i] > 0) any = 1'b1;
        rl = !any;
        if (rl) begin
            for (int i = 0; i < N; i++) begin
                w = int'(cfg_weight[WW*i +: WW]);
                m_credit[i] = (w == 0) ? 1 : w;
            end
        end
        for (int k = 0; k < N; k++) begin
            int j;
            j = (m_rr + k) % N;
            if (g < 0 && act[j] && m_credit[j] > 0) g = j;
        end
        m_rr = (g + 1) % N;
        m_credit[g] = m_credit[g] - 1;
    endtask

    task automatic randomize_req(input int i);
        req_we[i]              = 1'($urandom_range(0, 1));
        req_be[4*i +: 4]       = 4'($urandom);
        req_addr[32*i +: 32]   = $urandom;
        req_wdata[32*i +: 32]  = $urandom;
    endtask

    task automatic set_weights(input int w0, input int w1, input int w2, input int w3);
        cfg_weight = {4'(w3), 4'(w2), 4'(w1), 4'(w0)};
    endtask

    // Advance edge by edge until the port is owned; returns N+5 if it never is.
    task automatic wait_grant(output int edges);
        edges = 9;
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk); #1;
            dmem_if.rvalid = 1'b0;
            if (dmem_if.req) begin
                edges = e;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b0 || dmem_if.req !== 1'b0) begin
            bad++; $display("[TB] FAIL reset_busy: got busy=%b req=%b want 0 0", busy, dmem_if.req);
        end
        total++;
        if (rsp_valid !== 4'b0 || rsp_fault !== 1'b0 || rsp_rdata !== 32'h0) begin
            bad++; $display("[TB] FAIL reset_rsp: got %b %b %h want 0 0 0", rsp_valid, rsp_fault, rsp_rdata);
        end
        total++;
        if (grant_id !== 2'd0 || {dmem_if.we, dmem_if.be, dmem_if.addr, dmem_if.wdata} !== 69'h0) begin
            bad++; $display("[TB] FAIL reset_latch: got id=%0d addr=%h want 0 0", grant_id, dmem_if.addr);
        end
        rst_n = 1'b1;
        model_reset();
    endtask

    // Stream of n transactions with a fixed active set; lat_fixed < 0 picks a random
    // memory latency per transaction. Entered with the arbiter idle, shortly after an edge.
    task automatic test_stream(input logic [N-1:0] act, input int n, input int lat_fixed);
        int g, edges, exp_edges, lat;
        bit rl;
        logic [31:0] rd;
        logic        fl;
        logic [68:0] exp_f, got_f;
        logic [N-1:0] exp_oh;
        req_valid = act;
        for (int t = 0; t < n; t++) begin
            model_pick(act, g, rl);
            wait_grant(edges);
            exp_edges = ((t == 0) ? 1 : 2) + (rl ? 2 : 0);
            total++;
            if (edges !== exp_edges) begin
                bad++; $display("[TB] FAIL stream_grant_latency: got %0d edges want %0d", edges, exp_edges);
            end
            if (!dmem_if.req) begin
                req_valid = '0;
                return;
            end
            total++;
            if (grant_id !== 2'(g) || busy !== 1'b1) begin
                bad++; $display("[TB] FAIL stream_grant_id: got %0d busy=%b want %0d 1", grant_id, busy, g);
            end
            exp_f = {req_we[g], req_be[4*g +: 4], req_addr[32*g +: 32], req_wdata[32*g +: 32]};
            got_f = {dmem_if.we, dmem_if.be, dmem_if.addr, dmem_if.wdata};
            total++;
            if (got_f !== exp_f) begin
                bad++; $display("[TB] FAIL stream_fields: got %h want %h", got_f, exp_f);
            end
            lat = (lat_fixed < 0) ? int'($urandom_range(0, 3)) : lat_fixed;
            repeat (lat) begin
                #1;
                total++;
                if (rsp_valid !== 4'b0) begin
                    bad++; $display("[TB] FAIL stream_early_rsp: got %b want 0000", rsp_valid);
                end
                @(posedge clk); #1;
            end
            rd = $urandom;
            fl = 1'($urandom_range(0, 1));
            dmem_if.rdata  = rd;
            dmem_if.fault  = fl;
            dmem_if.rvalid = 1'b1;
            #1;
            exp_oh = 4'b0001 << g;
            total++;
            if (rsp_valid !== exp_oh || rsp_rdata !== rd || rsp_fault !== fl) begin
                bad++; $display("[TB] FAIL stream_rsp: got %b %h %b want %b %h %b",
                                rsp_valid, rsp_rdata, rsp_fault, exp_oh, rd, fl);
            end
            randomize_req(g);
            if (t == n - 1) req_valid = '0;
        end
        @(posedge clk); #1;
        dmem_if.rvalid = 1'b0;
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("[TB] FAIL stream_drain: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_first_request();
        set_weights(1, 1, 1, 1);
        randomize_req(0);
        test_stream(4'b0001, 1, 1);
    endtask

    task automatic test_weighted_rr();
        set_weights(1, 1, 1, 1);
        test_stream(4'b1111, 12, -1);
    endtask

    task automatic test_weights_310();
        set_weights(3, 1, 0, 0);
        test_stream(4'b0011, 12, -1);
        test_stream(4'b0100, 2, -1);
    endtask

    task automatic test_timeout();
        int g, edges, bc, hit;
        bit rl;
        logic [31:0] rd;
        req_valid = 4'b0001;
        model_pick(4'b0001, g, rl);
        dmem_if.rdata = 32'hDEAD_BEEF;
        dmem_if.fault = 1'b0;
        wait_grant(edges);
        total++;
        if (!dmem_if.req) begin
            bad++; $display("[TB] FAIL timeout_grant: got req=0 want 1");
            req_valid = '0;
            return;
        end
        bc  = 1;
        hit = 0;
        while (bc <= 20 && hit == 0) begin
            #1;
            if (rsp_valid !== 4'b0) hit = bc;
            else begin
                @(posedge clk); #1;
                bc++;
            end
        end
        total++;
        if (hit !== TO) begin
            bad++; $display("[TB] FAIL timeout_cycle: got %0d want %0d", hit, TO);
        end
        total++;
        if (rsp_valid !== 4'b0001 || rsp_fault !== 1'b1 || rsp_rdata !== 32'h0) begin
            bad++; $display("[TB] FAIL timeout_rsp: got %b %b %h want 0001 1 0", rsp_valid, rsp_fault, rsp_rdata);
        end
        req_valid = '0;
        @(posedge clk); #1;
        dmem_if.rvalid = 1'b1;
        repeat (3) begin
            #1;
            total++;
            if (rsp_valid !== 4'b0 || busy !== 1'b0) begin
                bad++; $display("[TB] FAIL late_rvalid: got rsp=%b busy=%b want 0000 0", rsp_valid, busy);
            end
            @(posedge clk); #1;
        end
        dmem_if.rvalid = 1'b0;

        // Response arriving in the very cycle the timeout would fire.
        req_valid = 4'b0001;
        model_pick(4'b0001, g, rl);
        wait_grant(edges);
        total++;
        if (!dmem_if.req) begin
            bad++; $display("[TB] FAIL tie_grant: got req=0 want 1");
            req_valid = '0;
            return;
        end
        repeat (TO - 1) begin
            @(posedge clk); #1;
        end
        rd = $urandom;
        dmem_if.rdata  = rd;
        dmem_if.fault  = 1'b0;
        dmem_if.rvalid = 1'b1;
        #1;
        total++;
        if (rsp_valid !== 4'b0001 || rsp_fault !== 1'b0 || rsp_rdata !== rd) begin
            bad++; $display("[TB] FAIL tie_rsp: got %b %b %h want 0001 0 %h", rsp_valid, rsp_fault, rsp_rdata, rd);
        end
        req_valid = '0;
        @(posedge clk); #1;
        dmem_if.rvalid = 1'b0;
    endtask

    task automatic test_hold_latch();
        int g, edges;
        bit rl;
        logic [31:0] orig;
        randomize_req(2);
        req_valid = 4'b0100;
        model_pick(4'b0100, g, rl);
        wait_grant(edges);
        total++;
        if (grant_id !== 2'd2 || !dmem_if.req) begin
            bad++; $display("[TB] FAIL hold_grant: got id=%0d req=%b want 2 1", grant_id, dmem_if.req);
        end
        orig = req_addr[64 +: 32];
        @(posedge clk); #1;
        req_addr[64 +: 32] = ~orig;
        req_valid = '0;
        repeat (3) begin
            #1;
            total++;
            if (dmem_if.addr !== orig || busy !== 1'b1) begin
                bad++; $display("[TB] FAIL hold_addr: got %h busy=%b want %h 1", dmem_if.addr, busy, orig);
            end
            @(posedge clk); #1;
        end
        dmem_if.rdata  = $urandom;
        dmem_if.fault  = 1'b0;
        dmem_if.rvalid = 1'b1;
        #1;
        total++;
        if (rsp_valid !== 4'b0100) begin
            bad++; $display("[TB] FAIL hold_rsp: got %b want 0100", rsp_valid);
        end
        @(posedge clk); #1;
        dmem_if.rvalid = 1'b0;
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("[TB] FAIL hold_drain: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] act;
        for (int s = 0; s < 6; s++) begin
            set_weights($urandom_range(0, 15), $urandom_range(0, 15),
                        $urandom_range(0, 15), $urandom_range(0, 15));
            act = 4'($urandom_range(1, 15));
            for (int i = 0; i < N; i++) randomize_req(i);
            test_stream(act, $urandom_range(3, 8), -1);
        end
    endtask

    task automatic test_reset_busy();
        int edges;
        set_weights(2, 2, 2, 2);
        req_valid = 4'b0001;
        wait_grant(edges);
        total++;
        if (!dmem_if.req) begin
            bad++; $display("[TB] FAIL rstbusy_grant: got req=0 want 1");
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        dmem_if.rvalid = 1'b1;
        #1;
        total++;
        if (dmem_if.req !== 1'b0 || busy !== 1'b0 || rsp_valid !== 4'b0) begin
            bad++; $display("[TB] FAIL rstbusy_outputs: got req=%b busy=%b rsp=%b want 0 0 0000",
                            dmem_if.req, busy, rsp_valid);
        end
        dmem_if.rvalid = 1'b0;
        req_valid = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        randomize_req(0);
        test_stream(4'b0001, 1, -1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        req_valid = '0;
        req_we    = '0;
        req_be    = '0;
        req_addr  = '0;
        req_wdata = '0;
        cfg_weight = '0;
        dmem_if.rvalid = 1'b0;
        dmem_if.rdata  = '0;
        dmem_if.fault  = 1'b0;
        model_reset();

        test_reset();
        test_first_request();
        test_weighted_rr();
        test_weights_310();
        test_timeout();
        test_hold_latch();
        test_random();
        test_reset_busy();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
